// File: rtl/riscv_result_checker_pkg.sv
// Shared types and constants for the riscv_result_checker slice.
package riscv_result_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_FAIL_VAL = 32'hDEADDEAD;

endpackage

// File: rtl/riscv_result_checker_table.sv
// result_table: expected-result storage {NINST, ANS}, synchronous write, combinational read.
module result_table #(
    parameter int NUM_TEST = 22,
    parameter int IDX_W    = 5
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [IDX_W-1:0] wa,
    input  logic [63:0]      wdata,
    input  logic [IDX_W-1:0] ra,
    output logic [63:0]      rdata
);

    localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(NUM_TEST);

    logic [63:0] mem [NUM_TEST];

    always_ff @(posedge CLK) begin
        if (we && ({1'b0, wa} < DEPTH))
            mem[wa] <= wdata;
    end

    always_comb begin
        rdata = '0;
        if ({1'b0, ra} < DEPTH)
            rdata = mem[ra];
    end

endmodule

// File: rtl/riscv_result_checker.sv
// Compares core NUM_INST/OUTPUT_PORT against a loaded expected-result table.
// Optional watchdog enabled by defining RESULT_CHECKER_TIMEOUT_EN.
module riscv_result_checker
    import riscv_result_checker_pkg::*;
#(
    parameter int          NUM_TEST = 22,
    parameter int          IDX_W    = 5,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             TAB_WE,
    input  logic [IDX_W-1:0] TAB_WA,
    input  logic [31:0]      TAB_NINST,
    input  logic [31:0]      TAB_ANS,
    input  logic             START,
    input  logic [31:0]      NUM_INST,
    input  logic [31:0]      OUTPUT_PORT,
    input  logic             HALT,
    output logic [1:0]       STATE,
    output logic [IDX_W:0]   PASS_CNT,
    output logic [IDX_W-1:0] FAIL_IDX,
    output logic [31:0]      FAIL_VAL,
    output logic [31:0]      CYCLE,
    output logic             DONE,
    output logic             PASS
);

    localparam logic [IDX_W:0] NUM_TEST_W = (IDX_W+1)'(NUM_TEST);
    localparam logic [IDX_W:0] ONE        = (IDX_W+1)'(1);

    state_t         state;
    logic [IDX_W:0] n_valid, ptr, ptr_nxt, wa_ext;
    logic [63:0]    tab_rdata;
    logic [31:0]    exp_ninst, exp_ans;
    logic           tab_wr, active, good, bad;

    assign wa_ext   = {1'b0, TAB_WA};
    assign tab_wr   = TAB_WE && (state == ST_IDLE) && (wa_ext < NUM_TEST_W);
    assign STATE    = state;
    assign PASS_CNT = ptr;

    result_table #(
        .NUM_TEST (NUM_TEST),
        .IDX_W    (IDX_W)
    ) u_table (
        .CLK   (CLK),
        .we    (tab_wr),
        .wa    (TAB_WA),
        .wdata ({TAB_NINST, TAB_ANS}),
        .ra    (ptr[IDX_W-1:0]),
        .rdata (tab_rdata)
    );

    // A count at or beyond the current entry's NINST without a full match is a failure.
    always_comb begin
        exp_ninst = tab_rdata[63:32];
        exp_ans   = tab_rdata[31:0];
        active    = ptr < n_valid;
        good      = active && (NUM_INST == exp_ninst) && (OUTPUT_PORT == exp_ans);
        bad       = active && !good && (NUM_INST >= exp_ninst);
        ptr_nxt   = good ? ptr + ONE : ptr;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state    <= ST_IDLE;
            n_valid  <= '0;
            ptr      <= '0;
            FAIL_IDX <= '0;
            FAIL_VAL <= '0;
            CYCLE    <= '0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (tab_wr && (wa_ext >= n_valid))
                        n_valid <= wa_ext + ONE;
                    if (START) begin
                        state <= ST_RUN;
                        ptr   <= '0;
                        CYCLE <= '0;
                    end
                end
                ST_RUN: begin
`ifdef RESULT_CHECKER_TIMEOUT_EN
                    if (!bad && !HALT && (CYCLE == TIMEOUT)) begin
                        state    <= ST_FAIL;
                        ptr      <= ptr_nxt;
                        FAIL_IDX <= ptr_nxt[IDX_W-1:0];
                        FAIL_VAL <= TIMEOUT_FAIL_VAL;
                        DONE     <= 1'b1;
                    end else
`endif
                    begin
                        if (CYCLE != '1)
                            CYCLE <= CYCLE + 32'd1;
                        // Compare takes priority over HALT in the same cycle.
                        if (bad) begin
                            state    <= ST_FAIL;
                            FAIL_IDX <= ptr[IDX_W-1:0];
                            FAIL_VAL <= OUTPUT_PORT;
                            DONE     <= 1'b1;
                        end else begin
                            ptr <= ptr_nxt;
                            if (HALT) begin
                                state <= ST_DONE;
                                DONE  <= 1'b1;
                                PASS  <= (ptr_nxt == n_valid);
                                if (ptr_nxt != n_valid)
                                    FAIL_IDX <= ptr_nxt[IDX_W-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_result_checker.sv
// Scoreboard bench for riscv_result_checker; timeout scenario runs when RESULT_CHECKER_TIMEOUT_EN is defined.
module tb_riscv_result_checker;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        TAB_WE = 1'b0;
    logic [4:0]  TAB_WA = '0;
    logic [31:0] TAB_NINST = '0, TAB_ANS = '0;
    logic        START = 1'b0, HALT = 1'b0;
    logic [31:0] NUM_INST = '0, OUTPUT_PORT = '0;
    logic [1:0]  STATE;
    logic [5:0]  PASS_CNT;
    logic [4:0]  FAIL_IDX;
    logic [31:0] FAIL_VAL, CYCLE;
    logic        DONE, PASS;

    typedef struct packed {
        logic [1:0]  st;
        logic        done;
        logic        pass;
        logic [5:0]  pcnt;
        logic [4:0]  fidx;
        logic [31:0] fval;
    } obs_t;

    obs_t sb[$];
    obs_t exp_o, got;
    int   total = 0;
    int   bad = 0;

    riscv_result_checker #(.NUM_TEST(22), .IDX_W(5), .TIMEOUT(50)) dut (
        .CLK(CLK), .RSTn(RSTn), .TAB_WE(TAB_WE), .TAB_WA(TAB_WA),
        .TAB_NINST(TAB_NINST), .TAB_ANS(TAB_ANS), .START(START),
        .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
        .STATE(STATE), .PASS_CNT(PASS_CNT), .FAIL_IDX(FAIL_IDX),
        .FAIL_VAL(FAIL_VAL), .CYCLE(CYCLE), .DONE(DONE), .PASS(PASS)
    );

    always #5 CLK = ~CLK;

    function automatic obs_t sample();
        return {STATE, DONE, PASS, PASS_CNT, FAIL_IDX, FAIL_VAL};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0; START = 1'b0; HALT = 1'b0; TAB_WE = 1'b0;
        NUM_INST = '0; OUTPUT_PORT = '0;
        step(); step();
        RSTn = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] n, input logic [31:0] v);
        TAB_WE = 1'b1; TAB_WA = a; TAB_NINST = n; TAB_ANS = v;
        step();
        TAB_WE = 1'b0;
    endtask

    task automatic load3();
        wr(5'd0, 32'd1, 32'h0);
        wr(5'd1, 32'd2, 32'hCC);
        wr(5'd2, 32'd4, 32'h2DD);
    endtask

    task automatic start_run();
        START = 1'b1; step(); START = 1'b0;
    endtask

    task automatic drive(input logic [31:0] n, input logic [31:0] v, input logic h);
        NUM_INST = n; OUTPUT_PORT = v; HALT = h;
        step();
        HALT = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200 && !DONE; i++) step();
        total++;
        if (DONE !== 1'b1) begin
            bad++;
            $display("FAIL %s_wait DONE got=%b exp=1 (no completion within 200 cycles)", name, DONE);
        end
    endtask

    task automatic test_reset();
        do_reset();
        sb.push_back('{st:2'd0, done:1'b0, pass:1'b0, pcnt:6'd0, fidx:5'd0, fval:32'd0});
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL reset got=%h exp=%h", got, exp_o); end
        total++;
        if (CYCLE !== 32'd0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", CYCLE); end
    endtask

    // All entries match; a TAB_WE pulse in RUN must not alter entry 1.
    task automatic test_pass();
        do_reset(); load3(); start_run();
        TAB_WE = 1'b1; TAB_WA = 5'd1; TAB_NINST = 32'd2; TAB_ANS = 32'h55;
        drive(32'd0, 32'h11, 1'b0);
        TAB_WE = 1'b0;
        drive(32'd1, 32'h0, 1'b0);
        drive(32'd2, 32'hCC, 1'b0);
        drive(32'd3, 32'h99, 1'b0);
        drive(32'd4, 32'h2DD, 1'b0);
        sb.push_back('{st:2'd2, done:1'b1, pass:1'b1, pcnt:6'd3, fidx:5'd0, fval:32'd0});
        drive(32'd4, 32'h2DD, 1'b1);
        wait_done("pass");
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL pass got=%h exp=%h", got, exp_o); end
        total++;
        if (CYCLE !== 32'd6) begin bad++; $display("FAIL pass_cycle got=%0d exp=6", CYCLE); end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{st:2'd2, done:1'b1, pass:1'b1, pcnt:6'd3, fidx:5'd0, fval:32'd0});
        start_run(); step();
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL start_in_done got=%h exp=%h", got, exp_o); end
    endtask

    task automatic test_mismatch();
        do_reset(); load3(); start_run();
        drive(32'd1, 32'h0, 1'b0);
        sb.push_back('{st:2'd3, done:1'b1, pass:1'b0, pcnt:6'd1, fidx:5'd1, fval:32'hCD});
        drive(32'd2, 32'hCD, 1'b0);
        drive(32'd4, 32'h2DD, 1'b1);
        wait_done("mismatch");
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL mismatch got=%h exp=%h", got, exp_o); end
    endtask

    task automatic test_skip();
        do_reset(); load3(); start_run();
        drive(32'd1, 32'h0, 1'b0);
        drive(32'd2, 32'hCC, 1'b0);
        sb.push_back('{st:2'd3, done:1'b1, pass:1'b0, pcnt:6'd2, fidx:5'd2, fval:32'h77});
        drive(32'd5, 32'h77, 1'b0);
        wait_done("skip");
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL skip got=%h exp=%h", got, exp_o); end
    endtask

    task automatic test_early_halt();
        do_reset(); load3(); start_run();
        drive(32'd1, 32'h0, 1'b0);
        drive(32'd2, 32'hCC, 1'b0);
        sb.push_back('{st:2'd2, done:1'b1, pass:1'b0, pcnt:6'd2, fidx:5'd2, fval:32'd0});
        drive(32'd3, 32'h0, 1'b1);
        wait_done("early_halt");
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL early_halt got=%h exp=%h", got, exp_o); end
    endtask

    task automatic test_halt_with_compare();
        do_reset(); load3(); start_run();
        drive(32'd1, 32'h0, 1'b0);
        sb.push_back('{st:2'd3, done:1'b1, pass:1'b0, pcnt:6'd1, fidx:5'd1, fval:32'hCE});
        drive(32'd2, 32'hCE, 1'b1);
        wait_done("halt_mismatch");
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL halt_mismatch got=%h exp=%h", got, exp_o); end

        do_reset(); load3(); start_run();
        drive(32'd1, 32'h0, 1'b0);
        drive(32'd2, 32'hCC, 1'b0);
        sb.push_back('{st:2'd2, done:1'b1, pass:1'b1, pcnt:6'd3, fidx:5'd0, fval:32'd0});
        drive(32'd4, 32'h2DD, 1'b1);
        wait_done("halt_match");
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL halt_match got=%h exp=%h", got, exp_o); end
    endtask

    // Out-of-range write must not extend the valid-entry count.
    task automatic test_write_bounds();
        do_reset(); load3();
        wr(5'd25, 32'd9, 32'h9);
        start_run();
        drive(32'd1, 32'h0, 1'b0);
        drive(32'd2, 32'hCC, 1'b0);
        sb.push_back('{st:2'd2, done:1'b1, pass:1'b1, pcnt:6'd3, fidx:5'd0, fval:32'd0});
        drive(32'd4, 32'h2DD, 1'b0);
        drive(32'd4, 32'h2DD, 1'b1);
        wait_done("write_bounds");
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL write_bounds got=%h exp=%h", got, exp_o); end
    endtask

    task automatic test_reset_mid_run();
        do_reset(); load3(); start_run();
        drive(32'd1, 32'h0, 1'b0);
        drive(32'd2, 32'hCC, 1'b0);
        sb.push_back('{st:2'd0, done:1'b0, pass:1'b0, pcnt:6'd0, fidx:5'd0, fval:32'd0});
        RSTn = 1'b0;
        step();
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL reset_mid_run got=%h exp=%h", got, exp_o); end
        total++;
        if (CYCLE !== 32'd0) begin bad++; $display("FAIL reset_mid_run_cycle got=%0d exp=0", CYCLE); end
        RSTn = 1'b1;
    endtask

`ifdef RESULT_CHECKER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset(); load3(); start_run();
        NUM_INST = '0; OUTPUT_PORT = '0;
        sb.push_back('{st:2'd3, done:1'b1, pass:1'b0, pcnt:6'd0, fidx:5'd0, fval:32'hDEADDEAD});
        wait_done("timeout");
        exp_o = sb.pop_front(); got = sample();
        total++;
        if (got !== exp_o) begin bad++; $display("FAIL timeout got=%h exp=%h", got, exp_o); end
        total++;
        if (CYCLE !== 32'd50) begin bad++; $display("FAIL timeout_cycle got=%0d exp=50", CYCLE); end
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_back_to_back();
        test_mismatch();
        test_skip();
        test_early_halt();
        test_halt_with_compare();
        test_write_bounds();
        test_reset_mid_run();
`ifdef RESULT_CHECKER_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
